// File: rtl/send_all.sv
// send_all: transmit side of the inter-board link. Sends a {msg_type, number}
// transaction as two 6-bit words over a four-phase Request/Ack handshake.
module send_all #(
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned TIMEOUT      = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       send_en,
    input  logic [2:0] send_msg_type,
    input  logic [4:0] send_number,
    input  logic       Ack_in,
    output logic       Request_out,
    output logic [5:0] inter_data_out,
    output logic       ready,
    output logic       send_done,
    output logic       send_timeout
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP1 = 3'd1;
    localparam logic [2:0] REQ1   = 3'd2;
    localparam logic [2:0] ACK1   = 3'd3;
    localparam logic [2:0] GAP    = 3'd4;
    localparam logic [2:0] SETUP2 = 3'd5;
    localparam logic [2:0] REQ2   = 3'd6;
    localparam logic [2:0] ACK2   = 3'd7;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_msg;
    logic [4:0]  r_num;
    logic        r_ack_meta;
    logic        r_ack_s;
    logic        r_req;
    logic [5:0]  r_data;

    logic        w_reset;
    logic [2:0]  w_state_d;
    logic [2:0]  w_msg_src;
    logic [5:0]  w_data_d;
    logic        w_req_d;
    logic        w_done;
    logic        w_timeout;
    logic        w_to_hit;

    assign w_reset  = !rst || interboard_rst;
    assign w_to_hit = (r_cnt == TO_LAST);
    // Word 1 is loaded on the accept edge, before the payload register is written.
    assign w_msg_src = (r_state == IDLE) ? send_msg_type : r_msg;

    // Next-state decode; done/timeout pulse in the cycle the FSM leaves a wait state.
    always_comb begin
        w_state_d = r_state;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:   if (send_en) w_state_d = SETUP1;
            SETUP1: if (r_cnt == SETUP_LAST) w_state_d = REQ1;
            REQ1: begin
                if (r_ack_s) begin
                    w_state_d = ACK1;
                end else if (w_to_hit) begin
                    w_state_d = IDLE;
                    w_timeout = 1'b1;
                end
            end
            ACK1: begin
                if (!r_ack_s) begin
                    w_state_d = GAP;
                end else if (w_to_hit) begin
                    w_state_d = IDLE;
                    w_timeout = 1'b1;
                end
            end
            GAP:    if (r_cnt == GAP_LAST) w_state_d = SETUP2;
            SETUP2: if (r_cnt == SETUP_LAST) w_state_d = REQ2;
            REQ2: begin
                if (r_ack_s) begin
                    w_state_d = ACK2;
                end else if (w_to_hit) begin
                    w_state_d = IDLE;
                    w_timeout = 1'b1;
                end
            end
            ACK2: begin
                if (!r_ack_s) begin
                    w_state_d = IDLE;
                    w_done    = 1'b1;
                end else if (w_to_hit) begin
                    w_state_d = IDLE;
                    w_timeout = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        w_data_d = 6'd0;
        case (w_state_d)
            SETUP1, REQ1, ACK1: w_data_d = {3'b000, w_msg_src};
            SETUP2, REQ2, ACK2: w_data_d = {1'b0, r_num};
            default:            w_data_d = 6'd0;
        endcase
        w_req_d = (w_state_d == REQ1) || (w_state_d == REQ2);
    end

    // Two-flop synchroniser for the asynchronous Ack.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= Ack_in;
            r_ack_s    <= r_ack_meta;
        end
    end

    // FSM state, shared phase/timeout counter and output registers.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_req   <= 1'b0;
            r_data  <= 6'd0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_data  <= w_data_d;
            if ((w_state_d != r_state) || (r_state == IDLE)) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Payload capture on accept; dropped whenever the FSM returns to idle.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_msg <= 3'd0;
            r_num <= 5'd0;
        end else if ((r_state == IDLE) && send_en) begin
            r_msg <= send_msg_type;
            r_num <= send_number;
        end else if (w_state_d == IDLE) begin
            r_msg <= 3'd0;
            r_num <= 5'd0;
        end
    end

    assign Request_out    = r_req;
    assign inter_data_out = r_data;
    assign ready          = (r_state == IDLE);
    assign send_done      = w_done;
    assign send_timeout   = w_timeout;

endmodule

// File: tb/tb_send_all.sv
// Testbench for send_all: table-driven transfers plus hand-written corner cases,
// with a word scoreboard checked at each Request rising edge.
module tb_send_all;

    localparam int unsigned SETUP = 4;
    localparam int unsigned GAP   = 4;
    localparam int unsigned TO    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       interboard_rst = 1'b0;
    logic       send_en = 1'b0;
    logic [2:0] send_msg_type = 3'd0;
    logic [4:0] send_number = 5'd0;
    logic       Ack_in = 1'b0;
    logic       Request_out;
    logic [5:0] inter_data_out;
    logic       ready;
    logic       send_done;
    logic       send_timeout;

    always #5 clk = ~clk;

    send_all #(
        .SETUP_CYCLES(SETUP),
        .GAP_CYCLES  (GAP),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .interboard_rst(interboard_rst),
        .send_en       (send_en),
        .send_msg_type (send_msg_type),
        .send_number   (send_number),
        .Ack_in        (Ack_in),
        .Request_out   (Request_out),
        .inter_data_out(inter_data_out),
        .ready         (ready),
        .send_done     (send_done),
        .send_timeout  (send_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];

    // Other-board model: 0 = normal (Ack high 11 cycles), 1 = Ack tied low, 2 = Ack stuck high.
    int ack_mode = 0;
    int ack_hold = 0;
    always @(posedge clk) begin
        case (ack_mode)
            1: begin
                Ack_in   <= 1'b0;
                ack_hold <= 0;
            end
            2: if (Request_out && !Ack_in) Ack_in <= 1'b1;
            default: begin
                if (ack_hold > 0) begin
                    ack_hold <= ack_hold - 1;
                    if (ack_hold == 1) Ack_in <= 1'b0;
                end else if (Request_out && !Ack_in) begin
                    Ack_in   <= 1'b1;
                    ack_hold <= 11;
                end
            end
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pulse counters, Request length and scoreboard at each Request rise.
    int req_rises = 0;
    int done_cyc = 0;
    int to_cyc = 0;
    int cur_len = 0;
    int last_len = 0;
    int stab = 0;
    logic prev_req = 1'b0;
    logic [5:0] prev_data = 6'd0;
    always @(negedge clk) begin
        if (inter_data_out == prev_data) stab++;
        else stab = 1;
        if (Request_out && !prev_req) begin
            req_rises++;
            cur_len = 0;
            n_checks++;
            if (stab - 1 < int'(SETUP)) begin
                n_errors++;
                $display("FAIL setup_stable: %0d cycles, need >= %0d", stab - 1, SETUP);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_request: word %h, expected none", inter_data_out);
            end else begin
                chk("word", int'(inter_data_out), int'(exp_q.pop_front()));
            end
        end
        if (Request_out) cur_len++;
        else if (prev_req) last_len = cur_len;
        if (send_done) done_cyc++;
        if (send_timeout) to_cyc++;
        prev_req  = Request_out;
        prev_data = inter_data_out;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] m, input logic [4:0] n);
        send_msg_type = m;
        send_number   = n;
        send_en       = 1'b1;
        tick();
        send_en       = 1'b0;
    endtask

    // Waits for a done or timeout pulse, then one more cycle so the FSM is idle.
    task automatic wait_evt(input int budget);
        int d0 = done_cyc;
        int t0 = to_cyc;
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (done_cyc != d0 || to_cyc != t0) break;
        end
        if (i == budget) chk("wait_evt_budget", i, 0);
        tick();
    endtask

    typedef struct {
        logic [2:0] msg;
        logic [4:0] num;
        logic [5:0] w1;
        logic [5:0] w2;
    } vec_t;

    vec_t vecs[5];
    int d0, t0, r0, k;

    initial begin
        vecs[0] = '{3'd5, 5'd17, 6'h05, 6'h11};
        vecs[1] = '{3'd0, 5'd0,  6'h00, 6'h00};
        vecs[2] = '{3'd7, 5'd31, 6'h07, 6'h1F};
        vecs[3] = '{3'd2, 5'd9,  6'h02, 6'h09};
        vecs[4] = '{3'd3, 5'd21, 6'h03, 6'h15};

        repeat (3) tick();
        chk("rst_request", int'(Request_out), 0);
        chk("rst_data", int'(inter_data_out), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(send_done), 0);
        chk("rst_timeout", int'(send_timeout), 0);
        rst = 1'b1;
        tick();

        // Table-driven nominal transfers.
        for (int i = 0; i < 5; i++) begin
            d0 = done_cyc; t0 = to_cyc; r0 = req_rises;
            exp_q.push_back(vecs[i].w1);
            exp_q.push_back(vecs[i].w2);
            send(vecs[i].msg, vecs[i].num);
            chk("busy_ready", int'(ready), 0);
            wait_evt(300);
            chk("vec_done", done_cyc - d0, 1);
            chk("vec_timeout", to_cyc - t0, 0);
            chk("vec_requests", req_rises - r0, 2);
            chk("vec_ready", int'(ready), 1);
            chk("vec_req_low", int'(Request_out), 0);
            chk("vec_data_idle", int'(inter_data_out), 0);
        end

        // Busy drop: a send_en during ACK1 is ignored.
        d0 = done_cyc; r0 = req_rises;
        exp_q.push_back(6'h01);
        exp_q.push_back(6'h03);
        send(3'd1, 5'd3);
        k = 0;
        while (!(req_rises == r0 + 1 && !Request_out) && k < 200) begin
            tick();
            k++;
        end
        chk("busy_reach_ack1", k < 200 ? 1 : 0, 1);
        send(3'd2, 5'd9);
        wait_evt(300);
        chk("busy_done", done_cyc - d0, 1);
        chk("busy_requests", req_rises - r0, 2);
        exp_q.push_back(6'h02);
        exp_q.push_back(6'h09);
        send(3'd2, 5'd9);
        wait_evt(300);
        chk("busy_resend_done", done_cyc - d0, 2);

        // Timeout with Ack tied low.
        ack_mode = 1;
        tick();
        d0 = done_cyc; t0 = to_cyc; r0 = req_rises;
        exp_q.push_back(6'h05);
        send(3'd5, 5'd17);
        wait_evt(300);
        chk("to_pulse", to_cyc - t0, 1);
        chk("to_no_done", done_cyc - d0, 0);
        chk("to_req_len", last_len, int'(TO));
        chk("to_requests", req_rises - r0, 1);
        chk("to_req_low", int'(Request_out), 0);
        chk("to_ready", int'(ready), 1);

        // Stuck Ack after word 1.
        ack_mode = 2;
        d0 = done_cyc; t0 = to_cyc; r0 = req_rises;
        exp_q.push_back(6'h06);
        send(3'd6, 5'd10);
        wait_evt(300);
        chk("stuck_pulse", to_cyc - t0, 1);
        chk("stuck_no_done", done_cyc - d0, 0);
        chk("stuck_requests", req_rises - r0, 1);
        chk("stuck_ready", int'(ready), 1);
        ack_mode = 1;
        repeat (5) tick();
        ack_mode = 0;
        tick();

        // rst in REQ2.
        d0 = done_cyc; t0 = to_cyc; r0 = req_rises;
        exp_q.push_back(6'h04);
        exp_q.push_back(6'h0C);
        send(3'd4, 5'd12);
        k = 0;
        while (req_rises != r0 + 2 && k < 200) begin
            tick();
            k++;
        end
        chk("rst_reach_req2", k < 200 ? 1 : 0, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_req", int'(Request_out), 0);
        chk("mid_rst_data", int'(inter_data_out), 0);
        chk("mid_rst_ready", int'(ready), 1);
        repeat (20) tick();
        chk("mid_rst_no_done", done_cyc - d0, 0);
        chk("mid_rst_no_timeout", to_cyc - t0, 0);

        // interboard_rst in SETUP1.
        r0 = req_rises;
        send(3'd6, 5'd6);
        chk("ib_in_setup", int'(inter_data_out), 6'h06);
        interboard_rst = 1'b1;
        tick();
        interboard_rst = 1'b0;
        chk("ib_rst_req", int'(Request_out), 0);
        chk("ib_rst_data", int'(inter_data_out), 0);
        chk("ib_rst_ready", int'(ready), 1);
        repeat (15) tick();
        chk("ib_no_request", req_rises - r0, 0);
        chk("ib_no_done", done_cyc - d0, 0);
        chk("ib_no_timeout", to_cyc - t0, 0);

        // Back-to-back: send_en in the done cycle is dropped, next cycle is taken.
        d0 = done_cyc; r0 = req_rises;
        exp_q.push_back(6'h03);
        exp_q.push_back(6'h04);
        send(3'd3, 5'd4);
        k = 0;
        while (!send_done && k < 300) begin
            tick();
            k++;
        end
        chk("b2b_done_seen", k < 300 ? 1 : 0, 1);
        chk("b2b_ready_in_done", int'(ready), 0);
        send_msg_type = 3'd6;
        send_number   = 5'd6;
        send_en       = 1'b1;
        tick();
        send_msg_type = 3'd7;
        send_number   = 5'd31;
        exp_q.push_back(6'h07);
        exp_q.push_back(6'h1F);
        chk("b2b_ready_after", int'(ready), 1);
        tick();
        send_en = 1'b0;
        wait_evt(300);
        chk("b2b_done_total", done_cyc - d0, 2);
        chk("b2b_requests", req_rises - r0, 4);

        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
